instruction_fetch: RTL and testbench

Front-end stage directly upstream of instruction_decoder. Holds the PC and issues one word request at a time to instruction memory. Captures the returned 32-bit instruction and presents it with its PC to the decoder over a valid/ready handshake. Supports back-pressure and branch/jump redirects, discarding stale in-flight fetches.

---
 rtl/tinker_pkg.sv | 28 ++
 rtl/fetch_predecode.sv | 14 +
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker front end.
// FETCH_PREDECODE_EN enables the opcode/halt predecode path.
package tinker_pkg;

  localparam int INSTR_WIDTH  = 32;
  localparam int OPCODE_WIDTH = 5;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
  localparam logic [OPCODE_WIDTH-1:0] OPC_HALT = 5'h0F;

  // Halt: opcode field plus a zero literal field [11:0]
  localparam logic [INSTR_WIDTH-1:0] HALT_MASK = 32'hF800_0FFF;
  localparam logic [INSTR_WIDTH-1:0] HALT_PAT  = {OPC_HALT, 27'd0};

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt_word(
    input logic [INSTR_WIDTH-1:0] w
  );
    return (w & HALT_MASK) == HALT_PAT;
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational opcode and halt extraction for the fetch stage.
// Only instantiated when FETCH_PREDECODE_EN is defined.
module fetch_predecode
  import tinker_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0]  instr_i,
  output logic [OPCODE_WIDTH-1:0] opcode_o,
  output logic                    is_halt_o
);

  assign opcode_o  = instr_i[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign is_halt_o = is_halt_word(instr_i);

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding fetch stage: PC, imem request, decoder handoff.
// Optional FETCH_PREDECODE_EN adds opcode/halt outputs and HALTED state.
module instruction_fetch
  import tinker_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEF),
  parameter int                  INSTR_BYTES = 4
)(
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc
`ifdef FETCH_PREDECODE_EN
  ,
  output logic [OPCODE_WIDTH-1:0] instr_opcode,
  output logic                    instr_is_halt
`endif
);

  fetch_state_t         state_q;
  logic [PC_WIDTH-1:0]  pc_q;
  logic [PC_WIDTH-1:0]  req_pc_q;
  logic                 kill_q;
  logic                 valid_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]  ipc_q;

  logic [PC_WIDTH-1:0]  redir_pc;
  logic [PC_WIDTH-1:0]  seq_pc;

  assign redir_pc = redirect_pc & ~(PC_WIDTH'(3));
  assign seq_pc   = req_pc_q + PC_WIDTH'(INSTR_BYTES);

`ifdef FETCH_PREDECODE_EN
  logic held_halt;

  fetch_predecode u_predecode (
    .instr_i   (instr_q),
    .opcode_o  (instr_opcode),
    .is_halt_o (held_halt)
  );

  assign instr_is_halt = held_halt;
`endif

  assign imem_req_valid = reset_n
                       && (state_q == FETCH)
                       && !redirect_valid;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;

  // Fetch FSM: request, wait/kill, hold for decoder, redirects
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      kill_q   <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ipc_q    <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end else if (imem_req_ready) begin
            req_pc_q <= pc_q;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            kill_q <= 1'b0;
            if (redirect_valid) begin
              pc_q    <= redir_pc;
              state_q <= FETCH;
            end else if (kill_q) begin
              state_q <= FETCH;
            end else begin
              instr_q <= imem_rsp_data;
              ipc_q   <= req_pc_q;
              valid_q <= 1'b1;
              pc_q    <= seq_pc;
              state_q <= HOLD;
            end
          end else if (redirect_valid) begin
            pc_q   <= redir_pc;
            kill_q <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            valid_q <= 1'b0;
            pc_q    <= redir_pc;
            state_q <= FETCH;
          end else if (instr_ready) begin
            valid_q <= 1'b0;
`ifdef FETCH_PREDECODE_EN
            state_q <= held_halt ? HALTED : FETCH;
`else
            state_q <= FETCH;
`endif
          end
        end
`ifdef FETCH_PREDECODE_EN
        HALTED: begin
          if (redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= FETCH;
          end
        end
`endif
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a stream-level model.
// Covers FETCH_PREDECODE_EN when the macro is defined.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_PREDECODE_EN
  logic [4:0]  instr_opcode;
  logic        instr_is_halt;
`endif

  instruction_fetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_PREDECODE_EN
    ,
    .instr_opcode   (instr_opcode),
    .instr_is_halt  (instr_is_halt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory model state
  bit          mem_ready = 1'b1;
  int          lat = 1;
  bit          pending = 1'b0;
  bit          rsp_real = 1'b0;
  bit          spur = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  logic [31:0] ovr [logic [31:0]];

  // stream model state
  logic [31:0] exp_pc = 32'h2000;
  logic [31:0] hs_pc [$];
  logic [31:0] hs_ins [$];
  int          hs_cyc [$];
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    if (a == 32'h2000) return 32'hC044_3000;
    return a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: drive at negedge+1, sample acceptance at negedge+3
  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_req_ready = mem_ready;
      rsp_real = 1'b0;
      if (pending && cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(paddr);
        pending  = 1'b0;
        rsp_real = 1'b1;
      end else begin
        if (pending) cnt--;
        imem_rsp_valid = spur;
        imem_rsp_data  = spur ? 32'hDEAD_BEEF : 32'h0;
      end
      #2;
      if (reset_n && imem_req_valid && imem_req_ready) begin
        pending = 1'b1;
        paddr   = imem_addr;
        cnt     = lat - 1;
      end
    end
  end

  // compare process at negedge+2
  initial begin
    bit          hold_prev;
    logic [31:0] pi;
    logic [31:0] pp;
    hold_prev = 1'b0;
    pi = '0;
    pp = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset_n) begin
        exp_pc = 32'h2000;
        hold_prev = 1'b0;
        continue;
      end
      if (hold_prev) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_instr", instruction, pi);
        chk("hold_pc", instr_pc, pp);
      end
      chk("one_outstanding",
          32'(imem_req_valid && (pending || rsp_real)), 32'd0);
      chk("req_while_valid",
          32'(imem_req_valid && instr_valid), 32'd0);
      if (imem_req_valid && imem_req_ready)
        chk("fetch_addr", imem_addr, exp_pc);
`ifdef FETCH_PREDECODE_EN
      if (instr_valid)
        chk("opcode", 32'(instr_opcode), 32'(instruction[31:27]));
`endif
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (instr_valid && instr_ready) begin
        chk("hs_pc", instr_pc, exp_pc);
        chk("hs_instr", instruction, mem_word(exp_pc));
        hs_pc.push_back(instr_pc);
        hs_ins.push_back(instruction);
        hs_cyc.push_back(cyc);
        exp_pc = exp_pc + 32'd4;
      end
      hold_prev = instr_valid && !instr_ready && !redirect_valid;
      pi = instruction;
      pp = instr_pc;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    spur = 1'b0;
    pending = 1'b0;
    #2;
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_addr", imem_addr, 32'h2000);
    hs_pc.delete();
    hs_ins.delete();
    hs_cyc.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_acc(output logic [31:0] a, output int n);
    bit ok;
    ok = 1'b0;
    a = '0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (imem_req_valid && imem_req_ready) begin
        a = imem_addr;
        n = i;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL wait_acc: no request accepted within 40 cycles");
    end
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: instr_valid never rose in 40 cycles");
    end
  endtask

  task automatic wait_hs(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      #3;
      if (hs_pc.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL wait_hs: got %0d handoffs, wanted %0d",
               hs_pc.size(), n);
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          n;
    reset_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // sequential stream, 1-cycle memory
    instr_ready = 1'b1; mem_ready = 1'b1; lat = 1;
    do_reset();
    wait_acc(a, n);
    chk("first_addr", a, 32'h2000);
    wait_hs(3);
    if (hs_pc.size() >= 3) begin
      chk("seq_pc0", hs_pc[0], 32'h2000);
      chk("seq_pc1", hs_pc[1], 32'h2004);
      chk("seq_pc2", hs_pc[2], 32'h2008);
      chk("seq_ins0", hs_ins[0], 32'hC044_3000);
      chk("seq_ins1", hs_ins[1], 32'h1357_2004);
      chk("rate", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
    end

    // back-pressure in HOLD, spurious response ignored
    instr_ready = 1'b0;
    do_reset();
    wait_valid();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spur = (i == 1);
      #3;
      chk("bp_pc", instr_pc, 32'h2000);
      chk("bp_instr", instruction, 32'hC044_3000);
      chk("bp_noreq", 32'(imem_req_valid), 32'd0);
    end
    @(negedge clk);
    spur = 1'b0;
    instr_ready = 1'b1;
    wait_acc(a, n);
    chk("bp_next_addr", a, 32'h2004);

    // memory not ready for 3 cycles
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      spur = (i == 1);
      #3;
      chk("stall_req", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_addr, 32'h2000);
      @(negedge clk);
    end
    spur = 1'b0;
    mem_ready = 1'b1;
    wait_acc(a, n);
    chk("stall_acc_addr", a, 32'h2000);
    chk("stall_acc_now", 32'(n), 32'd0);
    wait_hs(1);
    if (hs_pc.size() >= 1) chk("stall_hs", hs_pc[0], 32'h2000);

    // redirect during WAIT, 3-cycle memory, unaligned target
    lat = 3;
    do_reset();
    wait_acc(a, n);
    @(negedge clk);
    redirect(32'h3002);
    wait_acc(a, n);
    chk("wait_redir_addr", a, 32'h3000);
    wait_hs(1);
    if (hs_pc.size() >= 1) chk("wait_redir_hs", hs_pc[0], 32'h3000);

    // redirect coinciding with response
    lat = 1;
    do_reset();
    wait_acc(a, n);
    @(negedge clk);
    redirect(32'h5000);
    wait_acc(a, n);
    chk("coin_addr", a, 32'h5000);
    wait_hs(1);
    if (hs_pc.size() >= 1) chk("coin_hs", hs_pc[0], 32'h5000);

    // redirect in HOLD together with instr_ready
    instr_ready = 1'b0;
    do_reset();
    wait_valid();
    @(negedge clk);
    instr_ready = 1'b1;
    redirect(32'h3000);
    wait_acc(a, n);
    chk("hold_redir_addr", a, 32'h3000);
    wait_hs(1);
    if (hs_pc.size() >= 1) chk("hold_redir_hs", hs_pc[0], 32'h3000);

    // PC wrap at top of address space
    do_reset();
    redirect(32'hFFFF_FFFC);
    wait_hs(2);
    if (hs_pc.size() >= 2) begin
      chk("wrap_pc0", hs_pc[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", hs_pc[1], 32'h0000_0000);
    end

    // halt word
    ovr[32'h4000] = 32'h7800_0000;
    do_reset();
    redirect(32'h4000);
`ifdef FETCH_PREDECODE_EN
    wait_valid();
    chk("halt_flag", 32'(instr_is_halt), 32'd1);
    chk("halt_opc", 32'(instr_opcode), 32'h0F);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      chk("halted_noreq", 32'(imem_req_valid), 32'd0);
      chk("halted_novalid", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    redirect(32'h2000);
    wait_acc(a, n);
    chk("resume_addr", a, 32'h2000);
`else
    wait_hs(2);
    if (hs_pc.size() >= 2) begin
      chk("haltword_ins", hs_ins[0], 32'h7800_0000);
      chk("haltword_next", hs_pc[1], 32'h4004);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
